// File: rtl/vec_norm_eval_if.sv
// Purpose: start/busy handshake and operand/result bus for vec_norm_eval.
// Latency: wires only, no state.
// Backpressure: none; a requester waits on busy_o and watches done_o.
// Ports: vec_bi (N*W packed operands, channel k at [k*W +: W]), mode_i,
//        start_i, busy_o, done_o, y_bo (SW-bit result).
interface vec_norm_eval_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = 2*W + $clog2(N);

  logic [N*W-1:0] vec_bi;
  logic           mode_i;
  logic           start_i;
  logic           busy_o;
  logic           done_o;
  logic [SW-1:0]  y_bo;

  // Requester side (controller FSM or testbench).
  modport master (
    output vec_bi, mode_i, start_i,
    input  busy_o, done_o, y_bo
  );

  // Evaluator side.
  modport slave (
    input  vec_bi, mode_i, start_i,
    output busy_o, done_o, y_bo
  );
endinterface

// File: rtl/vec_norm_eval.sv
// Purpose: floor(sqrt(sum x_k^2)) (mode 0) or sum x_k^2 (mode 1) over N unsigned W-bit channels.
// Latency: N*(W+1)+1 cycles in mode 1, N*(W+1)+RW+1 in mode 0, from the start-sampling edge to done_o.
// Backpressure: start_i is only taken in IDLE; requests while busy or in the done cycle are dropped.
// Ports: clk_i, rst_i (async active-low), bus (vec_norm_eval_if.slave).
module vec_norm_eval #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vec_norm_eval_if.slave bus
);
  localparam int SW   = 2*W + $clog2(N);
  localparam int RW   = (SW + 1) / 2;
  localparam int OW   = 2*RW;                 // radicand padded to whole bit pairs
  localparam int CMAX = (W > RW) ? W : RW;
  localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_SQRT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  vec_q, vec_d;
  logic            mode_q, mode_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   op_q, op_d;
  logic [RW+1:0]   rem_q, rem_d;
  logic [RW-1:0]   root_q, root_d;
  logic [SW-1:0]   y_q, y_d;

  // Datapath helpers shared by several states.
  logic [KW-1:0]   k_inc;
  logic [W-1:0]    ch_in, ch_nxt;
  logic [SW-1:0]   acc_sum;
  logic [RW+1:0]   rem_sh, trial;
  logic            root_bit;
  logic [RW:0]     root_ext;

  always_comb begin
    k_inc    = k_q + KW'(1);
    ch_in    = bus.vec_bi[W-1:0];
    ch_nxt   = vec_q[k_inc*W +: W];
    acc_sum  = acc_q + SW'(prod_q);
    // Restoring step: bring down the next radicand bit pair and try
    // subtracting 4*root+1. The remainder never exceeds 2*root, so its top
    // two bits are always zero before the shift.
    rem_sh   = {rem_q[RW-1:0], op_q[OW-1 -: 2]};
    trial    = {root_q, 2'b01};
    root_bit = (rem_sh >= trial);
    root_ext = {root_q, root_bit};
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mode_d   = mode_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    op_d     = op_q;
    rem_d    = rem_q;
    root_d   = root_q;
    y_d      = y_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          vec_d    = bus.vec_bi;
          mode_d   = bus.mode_i;
          acc_d    = '0;
          k_d      = '0;
          mcand_d  = {{W{1'b0}}, ch_in};
          mplier_d = ch_in;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end

      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = S_ACC;
      end

      S_ACC: begin
        acc_d = acc_sum;
        if (k_q != KW'(N-1)) begin
          // Preload the next channel so MUL starts multiplying immediately.
          k_d      = k_inc;
          mcand_d  = {{W{1'b0}}, ch_nxt};
          mplier_d = ch_nxt;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else if (mode_q) begin
          // Result is written on the edge into DONE so it is valid with done_o.
          y_d     = acc_sum;
          state_d = S_DONE;
        end else begin
          op_d    = OW'(acc_sum);
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = S_SQRT;
        end
      end

      S_SQRT: begin
        rem_d  = root_bit ? (rem_sh - trial) : rem_sh;
        root_d = root_ext[RW-1:0];
        op_d   = op_q << 2;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(RW-1)) begin
          y_d     = SW'(root_ext[RW-1:0]);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      y_q      <= y_d;
    end
  end

  // busy_o also covers the IDLE cycle in which a request is being accepted,
  // so a held start_i shows the done cycle as the only non-busy cycle
  // between operations. The rst_i term keeps busy_o low throughout reset.
  assign bus.busy_o = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                      ((state_q == S_IDLE) && bus.start_i && rst_i);
  assign bus.done_o = (state_q == S_DONE);
  assign bus.y_bo   = y_q;

endmodule

// File: tb/tb_vec_norm_eval.sv
// Purpose: randomized self-checking bench for vec_norm_eval against a plain-arithmetic model.
// Latency: checks done_o timing, busy_o length and results per operation.
// Backpressure: exercises ignored start pulses, held start_i and mid-operation reset.
module tb_vec_norm_eval;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2*W + $clog2(N);
  localparam int RW = (SW + 1) / 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  vec_norm_eval_if #(.W(W), .N(N)) bus ();

  vec_norm_eval #(.W(W), .N(N)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] v;
    v = '0;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  // Reference: sum of squares, then the largest r with r*r <= sum.
  function automatic longint unsigned model_y(input logic [N*W-1:0] v, input bit m);
    longint unsigned s;
    longint unsigned x;
    longint unsigned r;
    s = 0;
    for (int k = 0; k < N; k++) begin
      x = longint'(v[k*W +: W]);
      s += x * x;
    end
    if (m) return s;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int model_lat(input bit m);
    return N*(W+1) + 1 + (m ? 0 : RW);
  endfunction

  // One operation from a start pulse. With noise set, start_i/vec_bi/mode_i
  // are scrambled while the block is busy.
  task automatic run_op(input logic [N*W-1:0] v, input bit m, input bit noise, input string tag);
    int lat;
    int bcnt;
    longint unsigned exp_y;
    lat   = 0;
    bcnt  = 0;
    exp_y = model_y(v, m);
    @(negedge clk);
    bus.vec_bi  = v;
    bus.mode_i  = m;
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        lat = c;
        break;
      end
      if (bus.busy_o) bcnt++;
      if (noise) begin
        bus.start_i = 1'($urandom_range(0, 1));
        bus.vec_bi  = $urandom;
        bus.mode_i  = 1'($urandom_range(0, 1));
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(model_lat(m)));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(model_lat(m) - 1));
    check({tag, "_busy_in_done"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_y"}, 64'(bus.y_bo), exp_y);
    @(negedge clk);
    check({tag, "_done_one_pulse"}, 64'(bus.done_o), 64'd0);
    check({tag, "_y_held"}, 64'(bus.y_bo), exp_y);
  endtask

  initial begin
    logic [N*W-1:0] hv [6];
    bit             hm [6];
    int             dcnt;
    int             bcnt;
    int             idle;
    bit             seen;

    n_chk = 0;
    n_err = 0;
    rst_n       = 1'b0;
    bus.vec_bi  = '0;
    bus.mode_i  = 1'b0;
    bus.start_i = 1'b0;

    // Reset, then a quiet idle period.
    repeat (3) @(negedge clk);
    check("rst_y", 64'(bus.y_bo), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done_o) dcnt++;
      if (bus.busy_o) bcnt++;
    end
    check("idle_done", 64'(dcnt), 64'd0);
    check("idle_busy", 64'(bcnt), 64'd0);
    check("idle_y", 64'(bus.y_bo), 64'd0);

    // Directed vectors.
    run_op(pack4(3, 4, 0, 0), 1'b0, 1'b0, "v3400_norm");
    run_op(pack4(3, 4, 0, 0), 1'b1, 1'b0, "v3400_sumsq");
    run_op(pack4(255, 255, 255, 255), 1'b1, 1'b0, "vmax_sumsq");
    run_op(pack4(255, 255, 255, 255), 1'b0, 1'b0, "vmax_norm");
    run_op(pack4(1, 1, 1, 0), 1'b0, 1'b1, "v1110_noise");
    run_op(pack4(0, 0, 0, 0), 1'b0, 1'b0, "vzero_norm");

    // Randomized operations, some with mid-operation noise.
    for (int i = 0; i < 12; i++) begin
      run_op($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    // Held start_i with alternating vectors and modes.
    for (int i = 0; i < 6; i++) begin
      hv[i] = (i % 2 == 0) ? pack4(3, 4, 12, 0) : $urandom;
      hm[i] = 1'(i % 2);
    end
    @(negedge clk);
    bus.vec_bi  = hv[0];
    bus.mode_i  = hm[0];
    bus.start_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (bus.done_o) begin
          seen = 1'b1;
          break;
        end
      end
      check("held_done_seen", 64'(seen), 64'd1);
      check("held_y", 64'(bus.y_bo), model_y(hv[i], hm[i]));
      if (i < 5) begin
        bus.vec_bi = hv[i+1];
        bus.mode_i = hm[i+1];
        idle = 1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.busy_o) break;
          idle++;
        end
        check("held_gap", 64'(idle), 64'd1);
      end else begin
        bus.start_i = 1'b0;
      end
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    check("pre_rst_y_nonzero", 64'(bus.y_bo != '0), 64'd1);
    bus.vec_bi  = pack4(3, 4, 0, 0);
    bus.mode_i  = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    check("midop_busy_before", 64'(bus.busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_busy", 64'(bus.busy_o), 64'd0);
    check("midop_rst_done", 64'(bus.done_o), 64'd0);
    check("midop_rst_y", 64'(bus.y_bo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done_o) dcnt++;
      if (bus.busy_o) bcnt++;
    end
    check("after_rst_done", 64'(dcnt), 64'd0);
    check("after_rst_busy", 64'(bcnt), 64'd0);
    check("after_rst_y", 64'(bus.y_bo), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
